// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod.
// The master drives count controls; the slave (the counter) returns count and flags.
interface counter_updown_mod_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] d;
   logic             clr_ovf;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output en, up_dn, load, d, clr_ovf,
      input  q, tc, wrap, ovf
   );

   modport slave (
      input  en, up_dn, load, d, clr_ovf,
      output q, tc, wrap, ovf
   );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with clamped parallel load, terminal-count decode,
// one-cycle wrap pulse and sticky overflow flag.
module counter_updown_mod #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MOD_MAX  = (1 << WIDTH) - 1,
   parameter bit          SATURATE = 1'b0
) (
   input logic                  i_clk,
   input logic                  i_rst,
   counter_updown_mod_if.slave  bus
);
   localparam logic [WIDTH-1:0] LP_MAX   = MOD_MAX[WIDTH-1:0];
   // One bit wider so the clamp compare stays meaningful when MOD_MAX is all ones.
   localparam logic [WIDTH:0]   LP_MAX_X = {1'b0, LP_MAX};

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_ovf;

   logic             w_at_max;
   logic             w_at_zero;
   logic             w_tc;
   logic             w_bnd;
   logic [WIDTH-1:0] w_d_clamped;
   logic [WIDTH-1:0] w_q_nxt;

   assign w_at_max    = (r_q == LP_MAX);
   assign w_at_zero   = (r_q == '0);
   assign w_tc        = bus.up_dn ? w_at_max : w_at_zero;
   assign w_bnd       = bus.en & w_tc & ~bus.load;
   assign w_d_clamped = ({1'b0, bus.d} > LP_MAX_X) ? LP_MAX : bus.d;

   always_comb begin
      w_q_nxt = r_q;
      if (bus.load) begin
         w_q_nxt = w_d_clamped;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (w_at_max) w_q_nxt = SATURATE ? LP_MAX : '0;
            else          w_q_nxt = r_q + WIDTH'(1);
         end else begin
            if (w_at_zero) w_q_nxt = SATURATE ? '0 : LP_MAX;
            else           w_q_nxt = r_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_wrap <= w_bnd;
         // A boundary event on the same edge as a clear keeps the flag set.
         if (w_bnd)            r_ovf <= 1'b1;
         else if (bus.clr_ovf) r_ovf <= 1'b0;
      end
   end

   assign bus.q    = r_q;
   assign bus.tc   = w_tc;
   assign bus.wrap = r_wrap;
   assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: a wrapping mod-10 counter and a saturating mod-16 counter.
module tb_counter_updown_mod;
   logic i_clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 i_clk = ~i_clk;

   counter_updown_mod_if #(.WIDTH(4)) bus_a ();
   counter_updown_mod_if #(.WIDTH(4)) bus_b ();

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0)) u_dut_a (
      .i_clk (i_clk),
      .i_rst (rst_a),
      .bus   (bus_a)
   );

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(15), .SATURATE(1'b1)) u_dut_b (
      .i_clk (i_clk),
      .i_rst (rst_b),
      .bus   (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int q, input int wrap, input int ovf);
      check({tag, ".q"}, 32'(bus_a.q), q);
      check({tag, ".wrap"}, 32'(bus_a.wrap), wrap);
      check({tag, ".ovf"}, 32'(bus_a.ovf), ovf);
   endtask

   task automatic chk_b(input string tag, input int q, input int wrap, input int ovf);
      check({tag, ".q"}, 32'(bus_b.q), q);
      check({tag, ".wrap"}, 32'(bus_b.wrap), wrap);
      check({tag, ".ovf"}, 32'(bus_b.ovf), ovf);
   endtask

   int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.en = 0; bus_a.up_dn = 0; bus_a.load = 0; bus_a.d = 0; bus_a.clr_ovf = 0;
      bus_b.en = 0; bus_b.up_dn = 0; bus_b.load = 0; bus_b.d = 0; bus_b.clr_ovf = 0;
      tick();
      chk_a("a_reset", 0, 0, 0);
      check("a_reset.tc_dn", 32'(bus_a.tc), 1);
      bus_a.up_dn = 1;
      #1 check("a_reset.tc_up", 32'(bus_a.tc), 0);

      // Count up through the 9 -> 0 rollover.
      rst_a = 0; bus_a.en = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_a($sformatf("a_up%0d", i), exp_up[i], (i == 9) ? 1 : 0, (i >= 9) ? 1 : 0);
         check($sformatf("a_up%0d.tc", i), 32'(bus_a.tc), (exp_up[i] == 9) ? 1 : 0);
      end

      // Down from 0 wraps to 9.
      bus_a.en = 0; bus_a.load = 1; bus_a.d = 0;
      tick();
      chk_a("a_ld0", 0, 0, 1);
      bus_a.load = 0; bus_a.en = 1; bus_a.up_dn = 0;
      #1 check("a_ld0.tc_dn", 32'(bus_a.tc), 1);
      tick();
      chk_a("a_dn_wrap", 9, 1, 1);
      tick();
      chk_a("a_dn8", 8, 0, 1);
      tick();
      chk_a("a_dn7", 7, 0, 1);

      // Clear alone, then clamped load, then load overriding a boundary event.
      bus_a.en = 0; bus_a.clr_ovf = 1;
      tick();
      chk_a("a_clr", 7, 0, 0);
      bus_a.clr_ovf = 0; bus_a.load = 1; bus_a.d = 4'hC;
      tick();
      chk_a("a_clamp", 9, 0, 0);
      bus_a.en = 1; bus_a.up_dn = 1; bus_a.d = 3;
      #1 check("a_clamp.tc", 32'(bus_a.tc), 1);
      tick();
      chk_a("a_ld_bnd", 3, 0, 0);

      // Clear coincident with a wrap: set wins.
      bus_a.en = 0; bus_a.d = 9;
      tick();
      chk_a("a_ld9", 9, 0, 0);
      bus_a.load = 0; bus_a.en = 1; bus_a.clr_ovf = 1;
      tick();
      chk_a("a_clr_wrap", 0, 1, 1);
      bus_a.en = 0;
      tick();
      chk_a("a_clr_late", 0, 0, 0);
      bus_a.clr_ovf = 0;

      // Reset with a pending load at q=7 and ovf set.
      bus_a.load = 1; bus_a.d = 9;
      tick();
      bus_a.load = 0; bus_a.en = 1;
      tick();
      chk_a("a_pre_rst", 0, 1, 1);
      bus_a.en = 0; bus_a.load = 1; bus_a.d = 7;
      tick();
      chk_a("a_ld7", 7, 0, 1);
      rst_a = 1; bus_a.d = 5; bus_a.en = 1;
      tick();
      chk_a("a_rst_ld", 0, 0, 0);

      // Reset on what would be a boundary event discards wrap and ovf.
      rst_a = 0; bus_a.en = 0; bus_a.d = 9;
      tick();
      bus_a.load = 0; bus_a.en = 1; bus_a.up_dn = 1; rst_a = 1;
      tick();
      chk_a("a_rst_bnd", 0, 0, 0);
      rst_a = 0; bus_a.en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a($sformatf("a_hold%0d", i), 0, 0, 0);
      end

      // Saturating counter pinned at 15.
      rst_b = 0; bus_b.load = 1; bus_b.d = 14;
      tick();
      chk_b("b_ld14", 14, 0, 0);
      bus_b.load = 0; bus_b.en = 1; bus_b.up_dn = 1;
      tick();
      chk_b("b_up1", 15, 0, 0);
      check("b_up1.tc", 32'(bus_b.tc), 1);
      tick();
      chk_b("b_up2", 15, 1, 1);
      tick();
      chk_b("b_up3", 15, 1, 1);
      bus_b.up_dn = 0;
      tick();
      chk_b("b_dn", 14, 0, 1);
      bus_b.load = 1; bus_b.d = 0;
      tick();
      bus_b.load = 0;
      tick();
      chk_b("b_sat0", 0, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down modulo counter with parallel load, enable, terminal-count decode and overflow reporting. It is the general-purpose counting element of the catalog. It serves as a cycle counter, a divide-by-N prescaler and a loop index in datapath and control blocks. Width, modulus and wrap-versus-saturate behaviour are compile-time parameters.

## Interface

- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `MOD_MAX`, 2**WIDTH-1: highest count value. The counter spans 0..MOD_MAX. Legal range is 1..2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable.
- `up_dn`  input  1  direction; 1 = increment, 0 = decrement.
- `load`  input  1  parallel load strobe.
- `d`  input  WIDTH  load value.
- `clr_ovf`  input  1  clears the sticky overflow flag.
- `q`  output  WIDTH  current count, registered.
- `tc`  output  1  terminal count, combinational decode of `q` and `up_dn`.
- `wrap`  output  1  registered one-cycle pulse following a boundary event.
- `ovf`  output  1  sticky boundary-event flag, registered.

## Operation

- Per-edge priority is `rst` > `load` > `en` > hold.
- `rst`: `q`=0, `wrap`=0, `ovf`=0.
- `load`: `q` takes `d`, or MOD_MAX if `d` > MOD_MAX. `en` and `up_dn` are ignored on that edge, and a load is never a boundary event.
- `en`=1, `up_dn`=1:
  - If `q` < MOD_MAX, `q` increments by 1.
  - If `q`==MOD_MAX, this is a boundary event. `q` becomes 0 when SATURATE=0 and stays at MOD_MAX when SATURATE=1.
- `en`=1, `up_dn`=0:
  - If `q` > 0, `q` decrements by 1.
  - If `q`==0, this is a boundary event. `q` becomes MOD_MAX when SATURATE=0 and stays at 0 when SATURATE=1.
- `en`=0 with no load: `q` holds.
- Arithmetic runs at WIDTH bits. The comparison against MOD_MAX must be exact, because `q` never exceeds MOD_MAX. When MOD_MAX=2**WIDTH-1, wrap is the natural binary rollover.
- `tc` = (`up_dn` & `q`==MOD_MAX) | (~`up_dn` & `q`==0). It does not depend on `en`. A boundary event is therefore exactly `en` & `tc` & ~`load` & ~`rst`.
- `wrap` is 1 in the cycle after a boundary event and 0 otherwise. It fires in saturate mode too, on every enabled cycle spent pinned at the boundary.
- `ovf` is set by a boundary event and cleared by `clr_ovf`. If both occur on the same edge, set wins. `ovf` otherwise holds.
- `up_dn` may change on any cycle. The direction in force is the one sampled at the edge.

## Timing

- Latency is 1 cycle: `q`, `wrap` and `ovf` reflect the inputs sampled at the previous rising edge.
- `tc` is combinational from `q` and `up_dn`, with no register stage. Consumers sample it at the same edge as `en`.
- Reset takes effect at the first rising edge with `rst`=1. Outputs read 0 from that edge on. `tc` reads 1 if `up_dn`=0 at that point, since `q`=0.
- A reset asserted in the middle of a count, a load or an overflow discards all pending updates. There is no asynchronous path.
- A 1..1 boundary event with `load`=1 on the same edge loads and produces no `wrap` and no `ovf` set.
- MOD_MAX=1 degenerates to a toggle flip-flop: `tc` is true every cycle in one of the two directions.

## Test plan

- WIDTH=4, MOD_MAX=9, SATURATE=0:
  - `rst` then `en`=1, `up_dn`=1 for 12 cycles -> `q` runs 1..9,0,1,2. `tc`=1 only while `q`=9. `wrap`=1 only in the cycle `q`=0, and `ovf` stays 1 from then on.
  - From `q`=0, `up_dn`=0, `en`=1 -> `q`=9 next cycle. `wrap` pulses, `ovf` sets. Then `q`=8, 7.
  - `load`=1 with `d`=4'hC -> `q`=9 (clamped). `load`=1, `en`=1, `d`=3 while `q`=9 and `up_dn`=1 -> `q`=3, no `wrap`.
  - `clr_ovf`=1 on the same edge as a 9->0 wrap -> `ovf` stays 1. `clr_ovf`=1 alone on a later edge -> `ovf`=0.
- WIDTH=4, MOD_MAX=15, SATURATE=1: count up from 14 for 3 enabled cycles -> `q`=15,15,15. `wrap` pulses on the 2nd and 3rd cycles and `ovf`=1. Switch `up_dn`=0 -> `q`=14.
- Reset mid-operation:
  - Assert `rst` together with `load`=1, `d`=5 at `q`=7 -> `q`=0, `ovf`=0, `wrap`=0 at that edge.
  - Deassert `rst`, then `en`=0 for 3 cycles -> `q` holds at 0.
